ram_sp_ctrl: RTL and testbench
==============================

// Module: ram_sp_ctrl
// PURPOSE
//  Parametrised single-port synchronous RAM with a request/ready handshake.
//  After reset, a hardware clear sequencer writes CLEAR_VAL to every location.
//  Out-of-range accesses are rejected and flagged.
//  Serves as program/data memory for the CPU datapath and supersedes the fixed 4-bit/16-location store.
// PARAMETERS
//  DATA_W     8    data word width in bits
//  ADDR_W     5    address width in bits
//  DEPTH      32   number of locations; DEPTH <= 2**ADDR_W, need not be a power of 2
//  CLEAR_VAL  0    value written to every location by the post-reset clear
// PORTS
//  clk        in   1        rising-edge clock
//  rst        in   1        asynchronous reset, active-high
//  req        in   1        access request; accepted when req && ready
//  we         in   1        1 = write, 0 = read; sampled with req
//  addr       in   ADDR_W   word address
//  wdata      in   DATA_W   write data
//  ready      out  1        block can accept a request this cycle
//  rdata      out  DATA_W   read data; valid while rvalid=1, held otherwise
//  rvalid     out  1        one-cycle pulse, read data available
//  addr_err   out  1        one-cycle pulse, accepted request had addr >= DEPTH
//  busy       out  1        clear sequence in progress
// BEHAVIOUR
//  Reset values: ready=0, rdata=0, rvalid=0, addr_err=0, busy=1, clear counter=0, state=ST_CLEAR.
//  FSM states: ST_CLEAR and ST_IDLE.
//  ST_CLEAR:
//   - writes CLEAR_VAL at address clr_cnt each cycle and increments clr_cnt.
//   - after writing DEPTH-1, moves to ST_IDLE; busy=0 and ready=1 from the next cycle.
//   - the clear takes exactly DEPTH cycles after reset release.
//   - req is ignored (ready=0); no rvalid or addr_err is produced.
//  ST_IDLE: ready=1 every cycle; the block never back-pressures once cleared.
//  Write accepted, addr < DEPTH: mem[addr] <= wdata at this edge; no rvalid.
//  Read accepted, addr < DEPTH:
//   - rdata = mem[addr] and rvalid=1 in the cycle after acceptance (latency 1).
//   - back-to-back reads give back-to-back rvalid pulses.
//  Write then read of the same address in consecutive cycles: the read returns the new data.
//  Accepted request with addr >= DEPTH:
//   - a write is dropped with no memory change.
//   - a read returns rdata=0 with rvalid=1.
//   - addr_err=1 for one cycle, aligned with where rvalid would be.
//  rst asserted mid-operation: outputs return to reset values immediately and the clear restarts from 0.
//   A pending rvalid is cancelled. Memory contents are indeterminate until the clear completes.
//  Widths: clr_cnt is ADDR_W+1 bits wide, so DEPTH = 2**ADDR_W terminates without wrap.
// CONFIGURATION
//  RAM_PARITY_EN defined:
//   - each location stores DATA_W+1 bits; the extra bit is even parity of the data.
//   - added output par_err (1 bit), a one-cycle pulse with rvalid when the stored parity mismatches.
//   - the clear writes the correct parity for CLEAR_VAL.
//  RAM_PARITY_EN undefined: storage is DATA_W bits and the par_err port does not exist.
// STRUCTURE
//  Package ram_pkg:
//   - state enum (ST_CLEAR, ST_IDLE)
//   - function parity(data) for RAM_PARITY_EN
//   - default-width localparams
//  Sub-module ram_array:
//   - pure synchronous storage: one write port, registered read, no reset.
//   - ram_sp_ctrl owns the FSM, handshake, range check and parity.
// TESTING
//  1. Reset release, DEPTH=32 -> busy=1 for 32 cycles, then ready=1; every read returns 0x00.
//  2. Write 0xA5 @3, then read @3 next cycle -> rvalid next cycle, rdata=0xA5.
//  3. Reads @0,@1,@2 back-to-back after writing 0x11,0x22,0x33 -> three consecutive rvalid: 0x11,0x22,0x33.
//  4. DEPTH=20: write 0xFF @25, then read @25 -> addr_err pulses twice, rdata=0;
//     a later read @19 is unaffected.
//  5. Assert rst during a clear and during an in-flight read -> rvalid does not appear;
//     busy=1 for a full DEPTH cycles again.
//  6. RAM_PARITY_EN: force-flip a stored bit @7 via hierarchical access, read @7 -> par_err=1 with rvalid.

Source files
------------

// File: rtl/ram_pkg.sv
// ram_pkg: shared definitions for the single-port RAM controller.
//
//   state_e   controller state (clear sequence / idle service)
//   parity()  even-parity bit of a data word, zero-extended to PAR_MAX_W.
//             Only used when RAM_PARITY_EN is defined.
//   *_DEF     default widths and depth of the memory
package ram_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 5;
  localparam int DEPTH_DEF  = 32;

  // Widest data word the parity helper accepts. Narrower words are
  // zero-extended, which does not change their parity.
  localparam int PAR_MAX_W  = 64;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  // Even parity: the returned bit makes the total count of ones even.
  function automatic logic parity(input logic [PAR_MAX_W-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/ram_array.sv
// ram_array: plain synchronous storage, one shared read/write port.
//
//   clk    rising-edge clock
//   en     port enable; nothing happens when low
//   we     1 = write wdata to mem[addr], 0 = read mem[addr] into rdata
//   addr   word address, must be < DEPTH whenever en is high
//   wdata  write word
//   rdata  registered read word, updated only by an enabled read
module ram_array #(
  parameter int WORD_W = 8,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  // NOTE: the storage array has no reset so it maps onto RAM macros; all
  // sequential state here and elsewhere is updated with non-blocking <=
  // so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/ram_sp_ctrl.sv
// ram_sp_ctrl: single-port synchronous RAM with request/ready handshake,
// post-reset hardware clear and out-of-range rejection.
//
// Optional feature macro: RAM_PARITY_EN
//   defined   -> each word stores an extra even-parity bit; par_err port added
//   undefined -> plain DATA_W storage, no par_err port
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous reset, active-high
//   req       access request, accepted when req && ready
//   we        1 = write, 0 = read (sampled with req)
//   addr      word address
//   wdata     write data
//   ready     request can be accepted this cycle
//   rdata     read data, valid with rvalid, held otherwise
//   rvalid    one-cycle pulse, one cycle after an accepted read
//   addr_err  one-cycle pulse, accepted request had addr >= DEPTH
//   busy      post-reset clear in progress
//   par_err   (RAM_PARITY_EN) one-cycle pulse with rvalid on parity mismatch
module ram_sp_ctrl
  import ram_pkg::*;
#(
  parameter int                DATA_W    = DATA_W_DEF,
  parameter int                ADDR_W    = ADDR_W_DEF,
  parameter int                DEPTH     = DEPTH_DEF,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              addr_err,
  output logic              busy
`ifdef RAM_PARITY_EN
  ,
  output logic              par_err
`endif
);

`ifdef RAM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  // One extra bit so a DEPTH of 2**ADDR_W can still reach the last index
  // without the counter wrapping.
  localparam int                CNT_W     = ADDR_W + 1;
  localparam logic [CNT_W-1:0]  LAST_IDX  = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(DEPTH);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   clr_cnt_q, clr_cnt_d;

  logic               mem_en;
  logic               mem_we;
  logic [ADDR_W-1:0]  mem_addr;
  logic [MEM_W-1:0]   mem_wdata;
  logic [MEM_W-1:0]   mem_rdata;

  logic               in_range;
  logic               acc_read;
  logic               acc_err;
  logic               rvalid_q;
  logic               err_q;
  logic [DATA_W-1:0]  hold_q;
  logic [MEM_W-1:0]   wr_word;
  logic [MEM_W-1:0]   clr_word;

`ifdef RAM_PARITY_EN
  assign wr_word  = {parity(PAR_MAX_W'(wdata)), wdata};
  assign clr_word = {parity(PAR_MAX_W'(CLEAR_VAL)), CLEAR_VAL};
`else
  assign wr_word  = wdata;
  assign clr_word = CLEAR_VAL;
`endif

  assign in_range = ({1'b0, addr} < DEPTH_CNT);

  // NOTE: every signal driven in this block gets a default first, so no
  // path through the case leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    ready     = 1'b0;
    busy      = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = clr_word;
    acc_read  = 1'b0;
    acc_err   = 1'b0;

    case (state_q)
      ST_CLEAR: begin
        busy      = 1'b1;
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = clr_cnt_q[ADDR_W-1:0];
        mem_wdata = clr_word;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == LAST_IDX) begin
          state_d = ST_IDLE;
        end
      end

      ST_IDLE: begin
        ready = 1'b1;
        if (req) begin
          acc_read = !we;
          if (in_range) begin
            mem_en    = 1'b1;
            mem_we    = we;
            mem_addr  = addr;
            mem_wdata = wr_word;
          end else begin
            // Rejected: writes are dropped, reads return zero.
            acc_err = 1'b1;
          end
        end
      end

      default: state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
      rvalid_q  <= 1'b0;
      err_q     <= 1'b0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      rvalid_q  <= acc_read;
      err_q     <= acc_err;
      hold_q    <= rdata;
    end
  end

  ram_array #(
    .WORD_W (MEM_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk   (clk),
    .en    (mem_en),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

  // The array output is only meaningful in the cycle after a read, so it is
  // exposed then and the last presented value is held otherwise.
  always_comb begin
    rdata = hold_q;
    if (rvalid_q) begin
      rdata = err_q ? '0 : mem_rdata[DATA_W-1:0];
    end
  end

  assign rvalid   = rvalid_q;
  assign addr_err = err_q;

`ifdef RAM_PARITY_EN
  assign par_err = rvalid_q && !err_q &&
                   (parity(PAR_MAX_W'(mem_rdata[DATA_W-1:0])) != mem_rdata[DATA_W]);
`endif

endmodule

// File: tb/tb_ram_sp_ctrl.sv
// Testbench for ram_sp_ctrl. Two instances share one stimulus stream:
// dut0 with DEPTH=32 (= 2**ADDR_W) and dut1 with DEPTH=20. Each is
// compared against a behavioural model built from arrays and counters.
module tb_ram_sp_ctrl;

  localparam int DW = 8;
  localparam int AW = 5;
  localparam int NI = 2;
  localparam int MAXD = 32;

  int depth [NI] = '{32, 20};

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req = 1'b0;
  logic          we  = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wdata = '0;

  logic [NI-1:0] ready, busy, rvalid, addr_err, par_err;
  logic [DW-1:0] rdata [NI];

  int n_checks = 0;
  int n_errors = 0;

  // Model state
  int            cyc      [NI];
  logic [DW-1:0] mem_m    [NI][MAXD];
  bit            bad_m    [NI][MAXD];
  bit            e_rvalid [NI];
  bit            e_err    [NI];
  bit            e_par    [NI];
  logic [DW-1:0] e_rdata  [NI];

  always #5 clk = ~clk;

  ram_sp_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(32)) u_dut0 (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ready(ready[0]), .rdata(rdata[0]), .rvalid(rvalid[0]),
    .addr_err(addr_err[0]), .busy(busy[0])
`ifdef RAM_PARITY_EN
    , .par_err(par_err[0])
`endif
  );

  ram_sp_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(20)) u_dut1 (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ready(ready[1]), .rdata(rdata[1]), .rvalid(rvalid[1]),
    .addr_err(addr_err[1]), .busy(busy[1])
`ifdef RAM_PARITY_EN
    , .par_err(par_err[1])
`endif
  );

`ifndef RAM_PARITY_EN
  assign par_err = '0;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset(input int i);
    cyc[i]      = 0;
    e_rvalid[i] = 1'b0;
    e_err[i]    = 1'b0;
    e_par[i]    = 1'b0;
    e_rdata[i]  = '0;
    for (int k = 0; k < MAXD; k++) begin
      mem_m[i][k] = '0;   // the clear fills every location with CLEAR_VAL = 0
      bad_m[i][k] = 1'b0;
    end
  endtask

  task automatic check_outputs();
    for (int i = 0; i < NI; i++) begin
      bit rdy;
      rdy = (cyc[i] >= depth[i]);
      check($sformatf("ready%0d", i),    32'(ready[i]),    32'(rdy));
      check($sformatf("busy%0d", i),     32'(busy[i]),     32'(!rdy));
      check($sformatf("rvalid%0d", i),   32'(rvalid[i]),   32'(e_rvalid[i]));
      check($sformatf("rdata%0d", i),    32'(rdata[i]),    32'(e_rdata[i]));
      check($sformatf("addr_err%0d", i), 32'(addr_err[i]), 32'(e_err[i]));
`ifdef RAM_PARITY_EN
      check($sformatf("par_err%0d", i),  32'(par_err[i]),  32'(e_par[i]));
`endif
    end
  endtask

  // One clock cycle: check what the DUTs show now, then present the next
  // inputs and advance the model to what the coming edge should produce.
  task automatic tick(input bit r, input bit q, input bit w, input int a,
                      input logic [DW-1:0] d);
    @(negedge clk);
    check_outputs();
    rst   = r;
    req   = q;
    we    = w;
    addr  = a[AW-1:0];
    wdata = d;
    for (int i = 0; i < NI; i++) begin
      if (r) begin
        model_reset(i);
      end else begin
        bit rdy;
        rdy = (cyc[i] >= depth[i]);
        e_rvalid[i] = 1'b0;
        e_err[i]    = 1'b0;
        e_par[i]    = 1'b0;
        if (rdy && q) begin
          if (a < depth[i]) begin
            if (w) begin
              mem_m[i][a] = d;
              bad_m[i][a] = 1'b0;
            end else begin
              e_rvalid[i] = 1'b1;
              e_rdata[i]  = mem_m[i][a];
              e_par[i]    = bad_m[i][a];
            end
          end else begin
            e_err[i] = 1'b1;
            if (!w) begin
              e_rvalid[i] = 1'b1;
              e_rdata[i]  = '0;
            end
          end
        end
        if (cyc[i] < 1000) cyc[i]++;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick(1'b0, 1'b0, 1'b0, 0, '0);
  endtask

  task automatic wr(input int a, input logic [DW-1:0] d);
    tick(1'b0, 1'b1, 1'b1, a, d);
  endtask

  task automatic rd(input int a);
    tick(1'b0, 1'b1, 1'b0, a, '0);
  endtask

  // Reset asserted off the clock edge: outputs must drop immediately.
  task automatic async_reset();
    #2;
    rst = 1'b1;
    req = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      check($sformatf("rst_ready%0d", i),  32'(ready[i]),    32'd0);
      check($sformatf("rst_busy%0d", i),   32'(busy[i]),     32'd1);
      check($sformatf("rst_rvalid%0d", i), 32'(rvalid[i]),   32'd0);
      check($sformatf("rst_rdata%0d", i),  32'(rdata[i]),    32'd0);
      check($sformatf("rst_err%0d", i),    32'(addr_err[i]), 32'd0);
      model_reset(i);
    end
    tick(1'b1, 1'b0, 1'b0, 0, '0);
    tick(1'b0, 1'b0, 1'b0, 0, '0);   // release
  endtask

  initial begin
    for (int i = 0; i < NI; i++) model_reset(i);

    // Reset, clear sequence, then every location reads back as zero
    tick(1'b1, 1'b0, 1'b0, 0, '0);
    tick(1'b1, 1'b1, 1'b0, 3, '0);
    tick(1'b0, 1'b1, 1'b1, 4, 8'h77);  // ignored during the clear
    idle(20);
    rd(5);                             // ignored by dut0, accepted by dut1
    idle(12);
    for (int a = 0; a < 32; a++) rd(a);
    idle(2);

    // Write then immediately read back
    wr(3, 8'hA5);
    rd(3);
    idle(2);

    // Back-to-back reads
    wr(0, 8'h11);
    wr(1, 8'h22);
    wr(2, 8'h33);
    rd(0);
    rd(1);
    rd(2);
    idle(2);

    // Out-of-range for dut1, in range for dut0
    wr(25, 8'hFF);
    rd(25);
    rd(19);
    wr(19, 8'h5A);
    rd(19);
    idle(2);

    // Reset during an in-flight read, then again during the clear
    rd(3);
    async_reset();
    idle(10);
    rd(0);
    async_reset();
    idle(34);
    rd(3);
    rd(31);
    idle(1);

    // Randomised traffic
    for (int k = 0; k < 600; k++) begin
      tick(1'b0, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           int'($urandom_range(0, 31)), DW'($urandom));
    end
    idle(2);

`ifdef RAM_PARITY_EN
    // Corrupt one stored data bit at address 7 and read it back
    wr(7, 8'h5C);
    idle(1);
    u_dut0.u_array.mem[7][0] = ~u_dut0.u_array.mem[7][0];
    u_dut1.u_array.mem[7][0] = ~u_dut1.u_array.mem[7][0];
    for (int i = 0; i < NI; i++) begin
      mem_m[i][7] = mem_m[i][7] ^ 8'h01;
      bad_m[i][7] = 1'b1;
    end
    rd(7);
    rd(6);
    wr(7, 8'h3C);
    rd(7);
    idle(2);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
